ir_sensor_array: RTL and testbench

//   Multi-channel successor to the single-bit IR obstacle inverter. Per channel:

---
 rtl/ir_sensor_array.sv | 102 ++++++++++
 tb/tb_ir_sensor_array.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ir_sensor_array.sv
// Multi-channel IR obstacle front end: sync, polarity normalise, debounce.
// Define IR_STUCK_DET_EN to add the per-channel stuck-obstacle timers.
module ir_sensor_array #(
  parameter int NUM_CH        = 3,
  parameter int FILTER_CYCLES = 5000,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1,
  parameter int STUCK_CYCLES  = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] Sense_,
  output logic [NUM_CH-1:0] obstacles_,
  output logic              obstacle_any,
  output logic              changed,
  output logic [NUM_CH-1:0] stuck
);

  localparam logic [NUM_CH-1:0] IDLE =
    (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);

  if (FILTER_CYCLES < 1 || NUM_CH < 1 || STUCK_CYCLES < 1)
    $error("ir_sensor_array: bad parameter");
  if (CNT_W < 31 && (1 << CNT_W) <= FILTER_CYCLES)
    $error("ir_sensor_array: CNT_W too small");

  logic [NUM_CH-1:0] s1, s2, raw, upd;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= Sense_;
      s2 <= s1;
    end
  end

  always_comb begin
    raw = (ACTIVE_LOW != 0) ? ~s2 : s2;
    upd = '0;
    for (int i = 0; i < NUM_CH; i++)
      upd[i] = (raw[i] != obstacles_[i]) && (cnt[i] == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obstacles_ <= '0;
      changed    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= '0;
    end else begin
      changed <= |upd;
      for (int i = 0; i < NUM_CH; i++) begin
        if (raw[i] == obstacles_[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          obstacles_[i] <= raw[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign obstacle_any = |obstacles_;

`ifdef IR_STUCK_DET_EN
  localparam int TW = $clog2(STUCK_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(STUCK_CYCLES);
  localparam logic [TW-1:0] T_PRE = TW'(STUCK_CYCLES - 1);

  logic [TW-1:0] tmr [NUM_CH];

  // stuck rises on the edge that brings the timer to STUCK_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck <= '0;
      for (int i = 0; i < NUM_CH; i++)
        tmr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!obstacles_[i]) begin
          tmr[i]   <= '0;
          stuck[i] <= 1'b0;
        end else begin
          if (tmr[i] != T_MAX)
            tmr[i] <= tmr[i] + 1'b1;
          if (tmr[i] >= T_PRE)
            stuck[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign stuck = '0;
`endif

endmodule

// File: tb/tb_ir_sensor_array.sv
// Directed bench for ir_sensor_array (3 ch, filter 4, stuck 10).
// Stuck checks follow IR_STUCK_DET_EN when it is defined for the build.
module tb_ir_sensor_array;

`ifdef IR_STUCK_DET_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] Sense_;
  logic [2:0] obstacles_;
  logic       obstacle_any;
  logic       changed;
  logic [2:0] stuck;

  int vectors;
  int miscompares;

  ir_sensor_array #(
    .NUM_CH(3),
    .FILTER_CYCLES(4),
    .CNT_W(3),
    .ACTIVE_LOW(1),
    .STUCK_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Sense_(Sense_),
    .obstacles_(obstacles_),
    .obstacle_any(obstacle_any),
    .changed(changed),
    .stuck(stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_edge(input string tag, input int k,
                          input logic [2:0] eo, input logic ec);
    chk($sformatf("%s obs k%0d", tag, k), obstacles_, eo);
    chk($sformatf("%s any k%0d", tag, k), obstacle_any, |eo);
    chk($sformatf("%s chg k%0d", tag, k), changed, ec);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    Sense_      = 3'b000;

    // 1: reset with all sensors active, then release
    ticks(2);
    chk("rst obs", obstacles_, 3'b000);
    chk("rst chg", changed, 1'b0);
    chk("rst stk", stuck, 3'b000);
    chk("rst any", obstacle_any, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_edge("t1", k, (k >= 6) ? 3'b111 : 3'b000, k == 6);
    end

    // 2: clear, then a 3-cycle glitch on ch0 is dropped
    Sense_ = 3'b111;
    ticks(8);
    chk("t2 clear", obstacles_, 3'b000);
    Sense_ = 3'b110;
    ticks(3);
    Sense_ = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_edge("t2", k, 3'b000, 1'b0);
    end

    // 3: ch0 held low then released
    Sense_ = 3'b110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_edge("t3 set", k, (k >= 6) ? 3'b001 : 3'b000, k == 6);
    end
    Sense_ = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_edge("t3 clr", k, (k >= 6) ? 3'b000 : 3'b001, k == 6);
    end

    // 4: staggered ch1/ch2, then simultaneous
    Sense_ = 3'b101;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) Sense_ = 3'b001;
      chk_edge("t4 stag", k,
               {k >= 8, k >= 6, 1'b0}, (k == 6) || (k == 8));
    end
    Sense_ = 3'b111;
    ticks(8);
    chk("t4 idle", obstacles_, 3'b000);
    Sense_ = 3'b001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_edge("t4 sim", k, (k >= 6) ? 3'b110 : 3'b000, k == 6);
    end
    Sense_ = 3'b111;
    ticks(8);

    // 5: reset mid-count on ch0 while ch1 is asserted
    Sense_ = 3'b101;
    ticks(8);
    chk("t5 pre", obstacles_, 3'b010);
    Sense_ = 3'b100;
    ticks(4);
    chk("t5 cnt", obstacles_, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("t5 async obs", obstacles_, 3'b000);
    chk("t5 async chg", changed, 1'b0);
    tick();
    chk("t5 held", obstacles_, 3'b000);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_edge("t5", k, (k >= 6) ? 3'b011 : 3'b000, k == 6);
    end

    // 6: stuck detector on ch0
    Sense_ = 3'b111;
    ticks(8);
    chk("t6 pre obs", obstacles_, 3'b000);
    chk("t6 pre stk", stuck, 3'b000);
    Sense_ = 3'b110;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("t6 obs k%0d", k), obstacles_,
          (k >= 6) ? 3'b001 : 3'b000);
      chk($sformatf("t6 stk k%0d", k), stuck,
          {2'b00, STK && (k >= 16)});
    end
    Sense_ = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t6 fall obs k%0d", k), obstacles_,
          (k >= 6) ? 3'b000 : 3'b001);
      chk($sformatf("t6 fall stk k%0d", k), stuck,
          {2'b00, STK && (k < 7)});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
